turbo_output_sequencer: RTL and testbench

- Parametrised multi-bank output stage for the turbo encoder. It collects per-cycle encoder symbols ({xk,zk,zkp} or wider) and trellis-tail symbols into frame banks, then streams each complete frame out in order.
- It supersedes the fixed two-FIFO ping-pong read FSM. Block length, tail length, symbol width and bank count are generalised.
- It adds valid/ready backpressure on the output, frame markers, and sticky error flags.

---
 rtl/turbo_output_sequencer.sv | 154 +++++++++++++++
 tb/tb_turbo_output_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/turbo_output_sequencer.sv
// Multi-bank frame sequencer for turbo encoder output: collects data+tail symbols
// into frame banks and streams each complete frame out with valid/ready and markers.
module turbo_output_sequencer #(
  parameter int W_SYM     = 3,
  parameter int K_SHORT   = 1056,
  parameter int K_LONG    = 6144,
  parameter int TAIL_LEN  = 4,
  parameter int NUM_BANKS = 2,
  parameter int IDX_W     = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W_SYM-1:0] in_data,
  input  logic             in_tail,
  input  logic             in_len_sel,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_SYM-1:0] out_data,
  output logic             out_sof,
  output logic             out_eof,
  output logic             out_tail,
  output logic             out_len_sel,
  output logic             overflow,
  output logic             proto_err
);

  localparam int L_MAX  = K_LONG + TAIL_LEN;
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  localparam logic [IDX_W-1:0]  LF_SHORT  = IDX_W'(K_SHORT + TAIL_LEN);
  localparam logic [IDX_W-1:0]  LF_LONG   = IDX_W'(K_LONG + TAIL_LEN);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_TAIL  = IDX_W'(TAIL_LEN);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
  localparam logic [BANK_W-1:0] BANK_ONE  = BANK_W'(1);

  logic [W_SYM-1:0]     mem [NUM_BANKS][L_MAX];
  logic [NUM_BANKS-1:0] bank_len;
  logic [NUM_BANKS-1:0] full;
  logic [NUM_BANKS-1:0] full_nxt;

  logic [BANK_W-1:0] wr_bank;
  logic [BANK_W-1:0] rd_bank;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  logic             wr_len_eff;
  logic [IDX_W-1:0] wr_lf;
  logic             wr_last;
  logic             wr_exp_tail;
  logic             wr_fire;
  logic             wr_drop;

  logic [IDX_W-1:0] rd_lf;
  logic             rd_last;
  logic             rd_tail;
  logic             load;

  // The frame length is taken from in_len_sel on the first symbol, then from the latched copy.
  always_comb begin
    wr_len_eff  = (wr_idx == '0) ? in_len_sel : bank_len[wr_bank];
    wr_lf       = wr_len_eff ? LF_LONG : LF_SHORT;
    wr_last     = (wr_idx == (wr_lf - IDX_ONE));
    wr_exp_tail = (wr_idx >= (wr_lf - IDX_TAIL));
    in_ready    = ~full[wr_bank];
    wr_fire     = in_valid & in_ready;
    wr_drop     = in_valid & ~in_ready;
  end

  always_comb begin
    rd_lf   = bank_len[rd_bank] ? LF_LONG : LF_SHORT;
    rd_last = (rd_idx == (rd_lf - IDX_ONE));
    rd_tail = (rd_idx >= (rd_lf - IDX_TAIL));
    load    = (~out_valid | out_ready) & full[rd_bank];
  end

  // Write and read banks are never the same full bank, so set and clear cannot collide.
  always_comb begin
    full_nxt = full;
    if (wr_fire && wr_last) begin
      full_nxt[wr_bank] = 1'b1;
    end
    if (load && rd_last) begin
      full_nxt[rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank][wr_idx] <= in_data;
      if (wr_idx == '0) begin
        bank_len[wr_bank] <= in_len_sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= '0;
      wr_bank   <= '0;
      wr_idx    <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_drop) begin
        overflow <= 1'b1;
      end
      if (wr_fire) begin
        if (in_tail != wr_exp_tail) begin
          proto_err <= 1'b1;
        end
        if (wr_last) begin
          wr_idx  <= '0;
          wr_bank <= (wr_bank == LAST_BANK) ? '0 : wr_bank + BANK_ONE;
        end else begin
          wr_idx <= wr_idx + IDX_ONE;
        end
      end
    end
  end

  // Output register: loads a new symbol whenever it is empty or being consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank     <= '0;
      rd_idx      <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      out_tail    <= 1'b0;
      out_len_sel <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_data    <= mem[rd_bank][rd_idx];
      out_sof     <= (rd_idx == '0);
      out_eof     <= rd_last;
      out_tail    <= rd_tail;
      out_len_sel <= bank_len[rd_bank];
      if (rd_last) begin
        rd_idx  <= '0;
        rd_bank <= (rd_bank == LAST_BANK) ? '0 : rd_bank + BANK_ONE;
      end else begin
        rd_idx <= rd_idx + IDX_ONE;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_turbo_output_sequencer.sv
// Directed self-checking bench for turbo_output_sequencer with small frame lengths
// (40/128 data + 4 tail, two banks).
module tb_turbo_output_sequencer;

  typedef struct packed {
    logic [2:0] d;
    logic       sof;
    logic       eof;
    logic       tail;
    logic       len;
  } sym_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_data = '0;
  logic       in_tail = 1'b0;
  logic       in_len_sel = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_data;
  logic       out_sof;
  logic       out_eof;
  logic       out_tail;
  logic       out_len_sel;
  logic       overflow;
  logic       proto_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc = 0;
  int first_valid_cyc = -1;
  int last_wr_cyc = 0;
  int ready_mode = 1;
  logic stab_en = 1'b0;
  logic prev_v = 1'b0;
  logic prev_r = 1'b0;
  logic [7:0] prev_obs = '0;
  logic [31:0] ready_pat = 32'b1011_0010_0111_0001_1100_1010_0110_1101;

  sym_t exp_q[$];
  sym_t rec_q[$];
  int   rec_cyc[$];

  turbo_output_sequencer #(
    .W_SYM(3), .K_SHORT(40), .K_LONG(128), .TAIL_LEN(4), .NUM_BANKS(2), .IDX_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_tail(in_tail), .in_len_sel(in_len_sel),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eof(out_eof), .out_tail(out_tail), .out_len_sel(out_len_sel),
    .overflow(overflow), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic readyFor(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return ready_pat[cyc % 32];
  endfunction

  function automatic logic [2:0] symData(input int pat, input int i);
    int t;
    if (pat == 0) t = i;
    else if (pat == 1) t = i + 3;
    else t = 7 - i;
    return 3'(t & 7);
  endfunction

  // Drive one cycle of inputs, observe the outputs that will be handshaken at the next edge.
  task automatic applyStimulus(input logic v, input logic [2:0] d, input logic t, input logic l, input logic r);
    logic [7:0] obs;
    in_valid   = v;
    in_data    = d;
    in_tail    = t;
    in_len_sel = l;
    out_ready  = r;
    obs = {out_valid, out_data, out_sof, out_eof, out_tail, out_len_sel};
    if (stab_en && prev_v && !prev_r) checkOutput("hold_stable", obs, prev_obs);
    if (v && in_ready) acc++;
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (out_valid && r) begin
      rec_q.push_back(sym_t'({out_data, out_sof, out_eof, out_tail, out_len_sel}));
      rec_cyc.push_back(cyc);
    end
    prev_v   = out_valid;
    prev_r   = r;
    prev_obs = obs;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic writeFrame(input int n, input logic len, input int pat, input int bad, input int first, input int last);
    sym_t e;
    for (int i = first; i <= last; i++) begin
      e.d    = symData(pat, i);
      e.sof  = (i == 0);
      e.eof  = (i == n - 1);
      e.tail = (i >= n - 4);
      e.len  = len;
      exp_q.push_back(e);
      last_wr_cyc = cyc;
      applyStimulus(1'b1, e.d, e.tail || (i == bad), len, readyFor(ready_mode));
    end
  endtask

  task automatic drainUntil(input string tag, input int want, input int budget);
    int n = 0;
    while (rec_q.size() < want && n < budget) begin
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, readyFor(ready_mode));
      n++;
    end
    checkOutput(tag, rec_q.size(), want);
  endtask

  task automatic compareStream(input string tag);
    checkOutput(tag, rec_q.size(), exp_q.size());
    for (int i = 0; i < rec_q.size() && i < exp_q.size(); i++) begin
      checkOutput(tag, 32'(rec_q[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic clearRecords();
    exp_q.delete();
    rec_q.delete();
    rec_cyc.delete();
    first_valid_cyc = -1;
    acc = 0;
  endtask

  task automatic doReset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    prev_v = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_markers", {out_sof, out_eof, out_tail, out_len_sel}, 0);
    checkOutput("rst_flags", {overflow, proto_err}, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single short frame, no backpressure
    clearRecords();
    ready_mode = 1;
    writeFrame(44, 1'b0, 0, -1, 0, 43);
    drainUntil("t1_count", 44, 100);
    compareStream("t1_sym");
    checkOutput("t1_latency", first_valid_cyc - last_wr_cyc, 2);

    // Two stored frames (short, long) stream back to back
    clearRecords();
    ready_mode = 0;
    writeFrame(44, 1'b0, 0, -1, 0, 43);
    writeFrame(132, 1'b1, 1, -1, 0, 131);
    checkOutput("t2_in_ready_full", in_ready, 0);
    ready_mode = 1;
    drainUntil("t2_count", 176, 400);
    compareStream("t2_sym");
    if (rec_cyc.size() == 176) checkOutput("t2_no_gap", rec_cyc[175] - rec_cyc[0], 175);

    // Patterned backpressure with hold-stability checking
    clearRecords();
    ready_mode = 2;
    stab_en = 1'b1;
    writeFrame(44, 1'b0, 2, -1, 0, 43);
    drainUntil("t3_count", 44, 400);
    compareStream("t3_sym");
    stab_en = 1'b0;

    // Overflow with both banks full
    clearRecords();
    ready_mode = 0;
    writeFrame(44, 1'b0, 0, -1, 0, 43);
    writeFrame(44, 1'b0, 2, -1, 0, 43);
    checkOutput("t4_accepted", acc, 88);
    checkOutput("t4_in_ready", in_ready, 0);
    checkOutput("t4_no_overflow_yet", overflow, 0);
    applyStimulus(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_overflow", overflow, 1);
    checkOutput("t4_accepted_after_drop", acc, 88);
    ready_mode = 1;
    drainUntil("t4_count", 88, 300);
    compareStream("t4_sym");
    checkOutput("t4_overflow_sticky", overflow, 1);

    // Misplaced tail marker
    doReset();
    checkOutput("t5_overflow_cleared", overflow, 0);
    clearRecords();
    writeFrame(44, 1'b0, 1, 10, 0, 9);
    checkOutput("t5_no_err_yet", proto_err, 0);
    writeFrame(44, 1'b0, 1, 10, 10, 43);
    checkOutput("t5_proto_err", proto_err, 1);
    drainUntil("t5_count", 44, 100);
    compareStream("t5_sym");
    checkOutput("t5_proto_err_sticky", proto_err, 1);

    // Asynchronous reset in the middle of output
    clearRecords();
    writeFrame(44, 1'b0, 0, -1, 0, 43);
    drainUntil("t6_partial", 10, 100);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_rst_valid", out_valid, 0);
    checkOutput("t6_rst_data", out_data, 0);
    checkOutput("t6_rst_markers", {out_sof, out_eof, out_tail, out_len_sel}, 0);
    checkOutput("t6_rst_flags", {overflow, proto_err}, 0);
    checkOutput("t6_rst_in_ready", in_ready, 1);
    #1 rst = 1'b0;
    prev_v = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    clearRecords();
    writeFrame(44, 1'b0, 2, -1, 0, 43);
    drainUntil("t6_count", 44, 100);
    compareStream("t6_sym");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
